// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart_tx serializer with spaced start pulses.
// A guard interval between pulses stands in for the serializer's missing busy flag.
module uart_tx_fifo #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int DEPTH           = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    localparam int DIV        = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int GAP_CYCLES = 12 * DIV;
    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = $clog2(GAP_CYCLES + 1);

    // A pulse reloads GAP-1 so the next expiry lands exactly GAP cycles later;
    // reset loads one more so nothing fires inside the first GAP cycles.
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] RST_LOAD = CW'(GAP_CYCLES);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        GUARD
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic           empty;

    assign empty    = (level == '0);
    assign in_ready = rst_n && (level != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = !empty && ((state == IDLE) || (cnt == '0));
    assign busy     = !empty || (state == GUARD);

    // Storage: write the offered byte on every accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally; occupancy tracks push/pop balance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Pulse FSM: pop and pulse, then hold off for the guard interval
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= GUARD;
            cnt      <= RST_LOAD;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            if (pop) begin
                tx_start <= 1'b1;
                tx_data  <= mem[rd_ptr];
                state    <= GUARD;
                cnt      <= GAP_LOAD;
            end else if (state == GUARD) begin
                if (cnt == '0) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo.
// Reference model: queue of accepted bytes, each pulses at max(accept+1, prev+GAP).
module tb_uart_tx_fifo;

    localparam int CF    = 1000;
    localparam int BR    = 100;
    localparam int DEPTH = 4;
    localparam int GAP   = 12 * (CF / BR);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [2:0]  level;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int ecnt = 0;

    logic [7:0] q_data[$];
    int         q_acc[$];
    int         prev = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_start = 1'b0;
    logic       acc_last = 1'b0;
    int         acc_edge = 0;

    int         pe[$];
    logic [7:0] pd[$];

    uart_tx_fifo #(
        .CLOCK_FREQUENCY(CF),
        .BAUD_RATE(BR),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .level(level),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d",
                   tag, obs, exp, ecnt);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic r);
        logic acc;
        in_valid = v;
        in_data  = d;
        rst_n    = r;
        @(posedge clk);
        ecnt++;
        acc_last = 1'b0;
        if (!r) begin
            q_data.delete();
            q_acc.delete();
            prev    = ecnt + 1;
            m_data  = 8'h00;
            m_start = 1'b0;
        end else begin
            acc     = v && (q_data.size() != DEPTH);
            m_start = 1'b0;
            if (q_data.size() > 0 && ecnt >= q_acc[0] + 1 && ecnt >= prev + GAP) begin
                m_start = 1'b1;
                m_data  = q_data.pop_front();
                void'(q_acc.pop_front());
                prev = ecnt;
            end
            if (acc) begin
                q_data.push_back(d);
                q_acc.push_back(ecnt);
                acc_last = 1'b1;
                acc_edge = ecnt;
            end
        end
        #1;
        if (tx_start === 1'b1) begin
            pe.push_back(ecnt);
            pd.push_back(tx_data);
        end
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("level", 32'(level), 32'(q_data.size()));
        chk("in_ready", 32'(in_ready), 32'(r && (q_data.size() != DEPTH)));
        chk("busy", 32'(busy), 32'((q_data.size() != 0) || (ecnt < prev + GAP)));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        int r0;
        int fall;
        int i;
        int p01;
        logic [7:0] exp3 [6];
        logic [7:0] b;

        exp3[0] = 8'hEE; exp3[1] = 8'h01; exp3[2] = 8'h02;
        exp3[3] = 8'h03; exp3[4] = 8'h04; exp3[5] = 8'h05;

        // post-reset guard
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        r0 = ecnt;
        pe.delete(); pd.delete();
        tick(1'b1, 8'h41, 1'b1);
        fall = -1;
        for (int k = 0; k < 300; k++) begin
            tick(1'b0, 8'h00, 1'b1);
            if (pe.size() > 0 && busy === 1'b0 && fall < 0) fall = ecnt;
        end
        chk("guard_count", 32'(pe.size()), 32'd1);
        chk("guard_min", 32'(pe.size() > 0 && pe[0] - r0 >= GAP), 32'd1);
        chk("guard_data", 32'(pd.size() > 0 ? pd[0] : 8'h00), 32'h41);
        chk("busy_fall", 32'(pe.size() > 0 ? fall - pe[0] : -1), 32'(GAP));

        // latency from idle
        pe.delete(); pd.delete();
        tick(1'b1, 8'h55, 1'b1);
        r0 = ecnt;
        idle(2);
        chk("lat_edge", 32'(pe.size() > 0 ? pe[0] - r0 : -1), 32'd1);
        chk("lat_data", 32'(pd.size() > 0 ? pd[0] : 8'h00), 32'h55);
        chk("lat_level", 32'(level), 32'd0);
        idle(GAP + 10);

        // full and backpressure
        pe.delete(); pd.delete();
        tick(1'b1, 8'hEE, 1'b1);
        for (int k = 1; k <= 4; k++) tick(1'b1, 8'(k), 1'b1);
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        tick(1'b1, 8'h05, 1'b1);
        chk("full_reject", 32'(acc_last), 32'd0);
        for (int k = 0; k < 3 * GAP && !acc_last; k++) tick(1'b1, 8'h05, 1'b1);
        p01 = (pe.size() > 1) ? pe[1] : -1;
        chk("accept05_edge", 32'(acc_edge - p01), 32'd1);
        for (int k = 0; k < 8 * GAP && busy; k++) tick(1'b0, 8'h00, 1'b1);
        chk("full_count", 32'(pe.size()), 32'd6);
        for (int j = 0; j < 6; j++)
            chk("full_order", (j < pd.size()) ? 32'(pd[j]) : 32'hFFFF_FFFF, 32'(exp3[j]));
        for (int j = 1; j < 6; j++)
            chk("full_gap", (j < pe.size()) ? 32'(pe[j] - pe[j-1]) : 32'hFFFF_FFFF, 32'(GAP));

        // pointer wrap with continuous valid
        pe.delete(); pd.delete();
        i = 0;
        for (int k = 0; k < 20 * GAP && i < 10; k++) begin
            b = 8'hA0 + 8'(i);
            tick(1'b1, b, 1'b1);
            if (acc_last) i++;
        end
        chk("wrap_all_in", 32'(i), 32'd10);
        for (int k = 0; k < 8 * GAP && busy; k++) tick(1'b0, 8'h00, 1'b1);
        chk("wrap_count", 32'(pe.size()), 32'd10);
        for (int j = 0; j < 10; j++)
            chk("wrap_order", (j < pd.size()) ? 32'(pd[j]) : 32'hFFFF_FFFF, 32'(8'hA0 + j));

        // reset mid-stream
        pe.delete(); pd.delete();
        tick(1'b1, 8'hB1, 1'b1);
        tick(1'b1, 8'hB2, 1'b1);
        tick(1'b1, 8'hB3, 1'b1);
        chk("mid_pulse", 32'(pe.size()), 32'd1);
        tick(1'b0, 8'h00, 1'b0);
        r0 = ecnt;
        chk("mid_level", 32'(level), 32'd0);
        pe.delete(); pd.delete();
        tick(1'b1, 8'h7E, 1'b1);
        idle(2 * GAP + 10);
        chk("mid_count", 32'(pe.size()), 32'd1);
        chk("mid_data", 32'(pd.size() > 0 ? pd[0] : 8'h00), 32'h7E);
        chk("mid_min", 32'(pe.size() > 0 && pe[0] - r0 >= GAP), 32'd1);

        // randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            tick(1'($urandom_range(0, 2) == 0), 8'($urandom),
                 1'($urandom_range(0, 599) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-buffering feeder that sits directly upstream of the `uart_tx` serializer.
- Accepts bytes from on-chip producers through a valid/ready handshake and stores them in a small FIFO.
- Drives the serializer's `start`/`data` inputs with one-cycle start pulses.
- The serializer exposes no busy flag, so this block enforces a fixed guard interval between consecutive pulses. No byte is ever dropped or merged.

Parameters:
- CLOCK_FREQUENCY, 27000000: system clock frequency in Hz. Must match the serializer instance.
- BAUD_RATE, 115200: line rate. Must match the serializer instance.
- DEPTH, 16: number of FIFO entries. Power of two, ≥2.
- Derived, not overridable:
  - DIV = CLOCK_FREQUENCY / BAUD_RATE, integer division.
  - GAP_CYCLES = 12 × DIV. This is 2808 at the defaults.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  8  byte to enqueue.
- in_valid  in  1  producer offers in_data this cycle.
- in_ready  out  1  FIFO can accept a byte this cycle.
- tx_start  out  1  one-cycle start pulse; connects to the serializer `start`.
- tx_data  out  8  byte for the serializer; connects to `data`.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- busy  out  1  high when the FIFO is non-empty or the guard interval is running.

Behaviour:
- Synchronous, active-low reset:
  - Sampled on the rising clk edge while rst_n=0.
  - Output values during and after reset: tx_start=0, tx_data=8'h00, level=0, in_ready=0, busy=1.
  - FIFO is flushed and pointers are zeroed.
  - The FSM enters GUARD with the counter loaded so that no tx_start occurs within GAP_CYCLES cycles after the first cycle with rst_n=1. This protects a frame the serializer (which has no reset) may still be shifting.
- in_ready = (level != DEPTH) and not in reset. It is registered-state based; a pop in the same cycle does not raise in_ready when full.
- Push: in_valid & in_ready at edge t writes in_data. level increments at t+1.
- Push while full (in_ready=0) is ignored, and the producer must hold. Simultaneous push and pop leaves level unchanged.
- FIFO is circular. Read/write pointers are $clog2(DEPTH) bits and wrap naturally; no special case at wrap.
- FSM states:
  - IDLE:
    - If level=0, remain in IDLE.
    - Else pop the head into tx_data, assert tx_start for exactly one cycle, load the guard counter, and go to GUARD.
  - GUARD:
    - Count down.
    - On expiry with the FIFO non-empty, pop and pulse directly, with no IDLE cycle.
    - On expiry with the FIFO empty, go to IDLE.
- Timing:
  - Consecutive tx_start pulses are exactly GAP_CYCLES cycles apart while the FIFO stays non-empty.
  - A pulse is never closer than GAP_CYCLES to the previous one.
- Latency: a byte accepted at edge t into an empty FIFO with the FSM in IDLE gives tx_start high during cycle t+2, with tx_data valid in that same cycle.
- tx_data is registered and holds its value until the next pop. tx_start is registered and is never high for two consecutive cycles.
- Bytes leave in strict FIFO order.
- busy = (level != 0) or (state == GUARD). It is 0 only in IDLE with an empty FIFO.
- Reset asserted mid-operation: queued bytes are discarded. The rules above apply after rst_n rises.

Test Plan:
- Use CLOCK_FREQUENCY=1000, BAUD_RATE=100 (DIV=10, GAP_CYCLES=120) and DEPTH=4 unless stated.
- Post-reset guard: release rst_n at cycle 0, push 8'h41 at cycle 1 -> no tx_start before cycle 120; a single pulse occurs with tx_data=8'h41; busy falls 120 cycles after that pulse.
- Latency from idle: after the guard expires, push 8'h55 at edge t -> tx_start=1 during cycle t+2 only, tx_data=8'h55, level back to 0.
- Full and backpressure:
  - Hold the serializer in guard.
  - Push 8'h01..8'h04 -> level=4 and in_ready=0.
  - Offer 8'h05 -> it is not accepted.
  - Bytes emit in order 01,02,03,04, pulses exactly 120 cycles apart.
  - 8'h05 is accepted only after the first pop.
- Pointer wrap and simultaneous push/pop:
  - Stream 10 bytes 8'hA0..8'hA9, keeping in_valid high.
  - All 10 emit in order.
  - In a cycle with a push and a pop, level stays unchanged.
  - No byte is lost across the pointer wrap.
- Reset mid-stream: queue 3 bytes, assert rst_n=0 for 1 cycle right after the first pulse -> remaining bytes are discarded, level=0, and the next pushed byte 8'h7E pulses no earlier than 120 cycles after release.
- End-to-end with the serializer at the default parameters: enqueue "Hi\r\n" -> the line decodes as 8N1 frames 0x48, 0x69, 0x0D, 0x0A, with no corrupted or truncated frames.
